// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, FSM state type and packing helper for the normalizer
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int SUM_W  = 25;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [FP_W-1:0] pack_fp(input logic sign,
                                              input logic [EXP_W-1:0] exp,
                                              input logic [FRAC_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - post-add normalizer: carry fix-up, iterative one-bit-per-cycle
// left normalization, overflow/underflow flush, truncating single-precision output
module fp_normalizer
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  state_t state;
  state_t state_next;

  logic [MANT_W-1:0] mant_r;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;

  logic              accept;
  logic              sum_zero;
  logic              sum_carry;
  logic              sum_norm;
  logic              early_uf;
  logic [EXP_W-1:0]  exp_inc;
  logic [MANT_W-1:0] shift_mant;
  logic [EXP_W-1:0]  shift_exp;

  // Input classification and the single-step shift candidate.
  always_comb begin
    accept     = in_valid && in_ready;
    sum_zero   = (in_sum == '0);
    sum_carry  = in_sum[SUM_W-1];
    sum_norm   = (in_sum[SUM_W-1 -: 2] == 2'b01);
    early_uf   = (in_exp <= 8'd1);
    exp_inc    = in_exp + 8'd1;
    shift_mant = {mant_r[MANT_W-2:0], 1'b0};
    shift_exp  = exp_r - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sum_zero || sum_carry || sum_norm || early_uf) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_mant[MANT_W-1] || (shift_exp == 8'd1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Working registers and the registered result; the result only changes on an
  // accept or a SHIFT step, so it holds steady while DONE waits on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      mant_r        <= '0;
      exp_r         <= '0;
      sign_r        <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_r        <= in_sign;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            if (sum_zero) begin
              // Exact cancellation always yields +0.
              mant_r     <= '0;
              exp_r      <= '0;
              out_result <= '0;
            end else if (sum_carry) begin
              mant_r <= in_sum[SUM_W-1:1];
              exp_r  <= exp_inc;
              if (exp_inc == EXP_MAX) begin
                out_result   <= pack_fp(in_sign, EXP_MAX, '0);
                out_overflow <= 1'b1;
              end else begin
                out_result <= pack_fp(in_sign, exp_inc, in_sum[FRAC_W:1]);
              end
            end else if (sum_norm) begin
              mant_r     <= in_sum[MANT_W-1:0];
              exp_r      <= in_exp;
              out_result <= pack_fp(in_sign, in_exp, in_sum[FRAC_W-1:0]);
            end else if (early_uf) begin
              mant_r        <= in_sum[MANT_W-1:0];
              exp_r         <= in_exp;
              out_result    <= pack_fp(in_sign, '0, '0);
              out_underflow <= 1'b1;
            end else begin
              mant_r <= in_sum[MANT_W-1:0];
              exp_r  <= in_exp;
            end
          end
        end
        SHIFT: begin
          mant_r <= shift_mant;
          exp_r  <= shift_exp;
          if (shift_mant[MANT_W-1]) begin
            out_result <= pack_fp(sign_r, shift_exp, shift_mant[FRAC_W-1:0]);
          end else if (shift_exp == 8'd1) begin
            // Would need a subnormal; flush to signed zero instead.
            out_result    <= pack_fp(sign_r, '0, '0);
            out_underflow <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - directed vector table plus hand sequences for fp_normalizer
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_sum;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;

  typedef struct {
    logic [24:0] sum;
    logic [7:0]  exp;
    logic        sign;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          k;
  } vec_t;

  vec_t vecs[14];

  fp_normalizer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) xfer_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx, input int hold);
    int  n;
    int  cyc;
    int  x0;
    bit  rdy_bad;
    bit  stable_bad;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_sum   = v.sum;
    in_exp   = v.exp;
    in_sign  = v.sign;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = 25'h1555555;
    in_exp   = 8'h3C;
    in_sign  = ~v.sign;
    cyc = 0;
    rdy_bad = 1'b0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (in_ready) rdy_bad = 1'b1;
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.k));
    chk($sformatf("v%0d result", idx), out_result, v.res);
    chk($sformatf("v%0d overflow", idx), 32'(out_overflow), 32'(v.ovf));
    chk($sformatf("v%0d underflow", idx), 32'(out_underflow), 32'(v.unf));
    x0 = xfer_cnt;
    stable_bad = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || out_result !== v.res) stable_bad = 1'b1;
      if (in_ready) rdy_bad = 1'b1;
    end
    chk($sformatf("v%0d in_ready_low", idx), 32'(rdy_bad), 32'd0);
    chk($sformatf("v%0d hold_stable", idx), 32'(stable_bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d valid_dropped", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d ready_after", idx), 32'(in_ready), 32'd1);
    chk($sformatf("v%0d one_transfer", idx), 32'(xfer_cnt - x0), 32'd1);
  endtask

  initial begin
    int  n;
    bit  valid_seen;

    vecs[0]  = '{25'h0800000, 8'h7F, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0};
    vecs[1]  = '{25'h1000000, 8'h7F, 1'b0, 32'h40000000, 1'b0, 1'b0, 0};
    vecs[2]  = '{25'h1000000, 8'hFE, 1'b0, 32'h7F800000, 1'b1, 1'b0, 0};
    vecs[3]  = '{25'h0000001, 8'h7F, 1'b0, 32'h34000000, 1'b0, 1'b0, 23};
    vecs[4]  = '{25'h0000001, 8'h05, 1'b1, 32'h80000000, 1'b0, 1'b1, 4};
    vecs[5]  = '{25'h0000000, 8'h7F, 1'b1, 32'h00000000, 1'b0, 1'b0, 0};
    vecs[6]  = '{25'h0000001, 8'h01, 1'b0, 32'h00000000, 1'b0, 1'b1, 0};
    vecs[7]  = '{25'h0400000, 8'h80, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1};
    vecs[8]  = '{25'h1FFFFFF, 8'h80, 1'b0, 32'h40FFFFFF, 1'b0, 1'b0, 0};
    vecs[9]  = '{25'h0FFFFFF, 8'h7F, 1'b0, 32'h3FFFFFFF, 1'b0, 1'b0, 0};
    vecs[10] = '{25'h0000003, 8'h18, 1'b0, 32'h01400000, 1'b0, 1'b0, 22};
    vecs[11] = '{25'h0000001, 8'h18, 1'b0, 32'h00800000, 1'b0, 1'b0, 23};
    vecs[12] = '{25'h0000001, 8'h17, 1'b0, 32'h00000000, 1'b0, 1'b1, 22};
    vecs[13] = '{25'h1000000, 8'hFD, 1'b0, 32'h7F000000, 1'b0, 1'b0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_overflow", 32'(out_overflow), 32'd0);
    chk("rst out_underflow", 32'(out_underflow), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], i, (i == 0) ? 3 : 1);
    end

    // Reset on the 5th SHIFT cycle abandons the operation.
    in_sum   = 25'h0000001;
    in_exp   = 8'h7F;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midshift_rst out_valid", 32'(out_valid), 32'd0);
    chk("midshift_rst out_result", out_result, 32'd0);
    rst = 1'b0;
    #1;
    chk("midshift_rst in_ready", 32'(in_ready), 32'd1);
    valid_seen = 1'b0;
    n = x_start();
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) valid_seen = 1'b1;
    end
    chk("midshift_rst no_valid", 32'(valid_seen), 32'd0);
    chk("midshift_rst no_transfer", 32'(xfer_cnt - n), 32'd0);
    out_ready = 1'b0;
    run_vec(vecs[0], 100, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic int x_start();
    return xfer_cnt;
  endfunction

endmodule
